// File: rtl/memory_stage_if.sv
// Data-memory command/response bus: the memory stage is the master, the data memory the slave.
interface memory_stage_if;
  logic        mem_cmd_valid;
  logic        mem_cmd_ready;
  logic        mem_cmd_write;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_wmask;
  logic        mem_rvalid;
  logic [31:0] mem_rdata;

  modport master (
    output mem_cmd_valid, mem_cmd_write, mem_addr, mem_wdata, mem_wmask,
    input  mem_cmd_ready, mem_rvalid, mem_rdata
  );

  modport slave (
    input  mem_cmd_valid, mem_cmd_write, mem_addr, mem_wdata, mem_wmask,
    output mem_cmd_ready, mem_rvalid, mem_rdata
  );
endinterface

// File: rtl/memory_stage.sv
// Pipeline memory stage: issues one load/store at a time to the data memory and hands
// completed instructions (or bubbles) to writeback through registered outputs.
module memory_stage #(
  parameter logic [31:0] REGPC_NOP = 32'hffffffff,
  parameter logic [31:0] INST_NOP  = 32'h00000013
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  wb_branch_hazard,
  input  logic [31:0]           input_reg_pc,
  input  logic [31:0]           input_inst,
  input  logic [31:0]           input_alu_out,
  input  logic [31:0]           input_rs2_data,
  input  logic [3:0]            input_mem_wen,
  input  logic                  input_rf_wen,
  input  logic [3:0]            input_wb_sel,
  input  logic [4:0]            input_wb_addr,
  input  logic [2:0]            input_csr_cmd,
  input  logic                  input_jmp_flg,
  input  logic [31:0]           input_imm_i,
  output logic                  output_stall_flg,
  memory_stage_if.master        mem,
  output logic [31:0]           output_reg_pc,
  output logic [31:0]           output_inst,
  output logic [31:0]           output_alu_out,
  output logic [31:0]           output_mem_rdata,
  output logic                  output_rf_wen,
  output logic [3:0]            output_wb_sel,
  output logic [4:0]            output_wb_addr,
  output logic [2:0]            output_csr_cmd,
  output logic                  output_jmp_flg,
  output logic [31:0]           output_imm_i
);

  // state  | meaning
  // IDLE   | accepting from execute; non-memory ops pass straight to writeback
  // REQ    | command for the captured op offered to data memory
  // WAIT_R | load accepted by memory, waiting for read data
  // DRAIN  | flushed load still outstanding; its data is dropped on arrival
  typedef enum logic [1:0] {IDLE, REQ, WAIT_R, DRAIN} state_t;

  state_t r_state, w_next_state;

  logic [31:0] r_cap_reg_pc, r_cap_inst, r_cap_alu_out, r_cap_rs2_data, r_cap_imm_i;
  logic [3:0]  r_cap_mem_wen, r_cap_wb_sel;
  logic        r_cap_rf_wen, r_cap_jmp_flg;
  logic [4:0]  r_cap_wb_addr;
  logic [2:0]  r_cap_csr_cmd;

  logic        w_flush, w_in_mem_op, w_is_store, w_hs, w_complete;
  logic [1:0]  w_lane;
  logic [31:0] w_rshift, w_load_data;
  logic [15:0] w_half;

  logic [31:0] w_nxt_reg_pc, w_nxt_inst, w_nxt_alu_out, w_nxt_mem_rdata, w_nxt_imm_i;
  logic        w_nxt_rf_wen, w_nxt_jmp_flg;
  logic [3:0]  w_nxt_wb_sel;
  logic [4:0]  w_nxt_wb_addr;
  logic [2:0]  w_nxt_csr_cmd;

  assign w_flush     = wb_branch_hazard;
  assign w_in_mem_op = (input_mem_wen != 4'd0) || (input_wb_sel >= 4'd1 && input_wb_sel <= 4'd5);
  assign w_is_store  = (r_cap_mem_wen != 4'd0);
  assign w_lane      = r_cap_alu_out[1:0];
  assign w_hs        = mem.mem_cmd_valid && mem.mem_cmd_ready;
  assign w_complete  = ((r_state == REQ) && w_is_store && w_hs) ||
                       ((r_state == WAIT_R) && mem.mem_rvalid);

  always_ff @(posedge clk) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_next_state;
  end

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      IDLE:    if (!w_flush && w_in_mem_op) w_next_state = REQ;
      REQ: begin
        if (w_flush)    w_next_state = IDLE;
        else if (w_hs)  w_next_state = w_is_store ? IDLE : WAIT_R;
      end
      WAIT_R: begin
        if (mem.mem_rvalid) w_next_state = IDLE;
        else if (w_flush)   w_next_state = DRAIN;
      end
      DRAIN:   if (mem.mem_rvalid) w_next_state = IDLE;
      default: w_next_state = IDLE;
    endcase
  end

  // Load data: byte lanes picked by address, halves by address bit 1 (misaligned rounds down).
  always_comb begin
    w_rshift = mem.mem_rdata >> {w_lane, 3'b000};
    w_half   = w_lane[1] ? mem.mem_rdata[31:16] : mem.mem_rdata[15:0];
    case (r_cap_wb_sel)
      4'd1:    w_load_data = {{24{w_rshift[7]}}, w_rshift[7:0]};
      4'd2:    w_load_data = {24'h0, w_rshift[7:0]};
      4'd3:    w_load_data = {{16{w_half[15]}}, w_half};
      4'd4:    w_load_data = {16'h0, w_half};
      default: w_load_data = mem.mem_rdata;
    endcase
  end

  always_comb begin
    mem.mem_cmd_valid = (r_state == REQ) && !w_flush && !rst;
    mem.mem_cmd_write = w_is_store;
    mem.mem_addr      = {r_cap_alu_out[31:2], 2'b00};
    output_stall_flg  = (r_state != IDLE) && !w_complete;
    case (r_cap_mem_wen)
      4'd1: begin
        mem.mem_wmask = 4'b0001 << w_lane;
        mem.mem_wdata = {4{r_cap_rs2_data[7:0]}};
      end
      4'd2: begin
        mem.mem_wmask = 4'b0011 << {w_lane[1], 1'b0};
        mem.mem_wdata = {2{r_cap_rs2_data[15:0]}};
      end
      4'd3: begin
        mem.mem_wmask = 4'b1111;
        mem.mem_wdata = r_cap_rs2_data;
      end
      default: begin
        mem.mem_wmask = 4'b0000;
        mem.mem_wdata = r_cap_rs2_data;
      end
    endcase

    w_nxt_reg_pc    = REGPC_NOP;
    w_nxt_inst      = INST_NOP;
    w_nxt_alu_out   = 32'hffffffff;
    w_nxt_mem_rdata = 32'hffffffff;
    w_nxt_imm_i     = 32'hffffffff;
    w_nxt_rf_wen    = 1'b0;
    w_nxt_wb_sel    = 4'd0;
    w_nxt_wb_addr   = 5'd0;
    w_nxt_csr_cmd   = 3'd0;
    w_nxt_jmp_flg   = 1'b0;
    if (r_state == IDLE && !w_flush && !w_in_mem_op) begin
      w_nxt_reg_pc    = input_reg_pc;
      w_nxt_inst      = input_inst;
      w_nxt_alu_out   = input_alu_out;
      w_nxt_mem_rdata = 32'h0;
      w_nxt_imm_i     = input_imm_i;
      w_nxt_rf_wen    = input_rf_wen;
      w_nxt_wb_sel    = input_wb_sel;
      w_nxt_wb_addr   = input_wb_addr;
      w_nxt_csr_cmd   = input_csr_cmd;
      w_nxt_jmp_flg   = input_jmp_flg;
    end else if ((r_state == REQ && w_is_store && w_hs) ||
                 (r_state == WAIT_R && mem.mem_rvalid && !w_flush)) begin
      w_nxt_reg_pc    = r_cap_reg_pc;
      w_nxt_inst      = r_cap_inst;
      w_nxt_alu_out   = r_cap_alu_out;
      w_nxt_mem_rdata = (r_state == WAIT_R) ? w_load_data : 32'h0;
      w_nxt_imm_i     = r_cap_imm_i;
      w_nxt_rf_wen    = r_cap_rf_wen;
      w_nxt_wb_sel    = r_cap_wb_sel;
      w_nxt_wb_addr   = r_cap_wb_addr;
      w_nxt_csr_cmd   = r_cap_csr_cmd;
      w_nxt_jmp_flg   = r_cap_jmp_flg;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_cap_reg_pc   <= 32'h0;
      r_cap_inst     <= 32'h0;
      r_cap_alu_out  <= 32'h0;
      r_cap_rs2_data <= 32'h0;
      r_cap_imm_i    <= 32'h0;
      r_cap_mem_wen  <= 4'd0;
      r_cap_wb_sel   <= 4'd0;
      r_cap_rf_wen   <= 1'b0;
      r_cap_jmp_flg  <= 1'b0;
      r_cap_wb_addr  <= 5'd0;
      r_cap_csr_cmd  <= 3'd0;
    end else if (r_state == IDLE && !w_flush) begin
      r_cap_reg_pc   <= input_reg_pc;
      r_cap_inst     <= input_inst;
      r_cap_alu_out  <= input_alu_out;
      r_cap_rs2_data <= input_rs2_data;
      r_cap_imm_i    <= input_imm_i;
      r_cap_mem_wen  <= input_mem_wen;
      r_cap_wb_sel   <= input_wb_sel;
      r_cap_rf_wen   <= input_rf_wen;
      r_cap_jmp_flg  <= input_jmp_flg;
      r_cap_wb_addr  <= input_wb_addr;
      r_cap_csr_cmd  <= input_csr_cmd;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      output_reg_pc    <= REGPC_NOP;
      output_inst      <= INST_NOP;
      output_alu_out   <= 32'hffffffff;
      output_mem_rdata <= 32'hffffffff;
      output_imm_i     <= 32'hffffffff;
      output_rf_wen    <= 1'b0;
      output_wb_sel    <= 4'd0;
      output_wb_addr   <= 5'd0;
      output_csr_cmd   <= 3'd0;
      output_jmp_flg   <= 1'b0;
    end else begin
      output_reg_pc    <= w_nxt_reg_pc;
      output_inst      <= w_nxt_inst;
      output_alu_out   <= w_nxt_alu_out;
      output_mem_rdata <= w_nxt_mem_rdata;
      output_imm_i     <= w_nxt_imm_i;
      output_rf_wen    <= w_nxt_rf_wen;
      output_wb_sel    <= w_nxt_wb_sel;
      output_wb_addr   <= w_nxt_wb_addr;
      output_csr_cmd   <= w_nxt_csr_cmd;
      output_jmp_flg   <= w_nxt_jmp_flg;
    end
  end

endmodule

// File: tb/tb_memory_stage.sv
// Bench for memory_stage: directed corner cases then random loads/stores against a
// behavioural model of lane selection, masking and sign extension.
module tb_memory_stage;
  localparam logic [31:0] PC_NOP = 32'hffffffff;
  localparam logic [31:0] I_NOP  = 32'h00000013;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] inst;
    logic [31:0] alu;
    logic [31:0] rs2;
    logic [31:0] imm;
    logic [3:0]  mem_wen;
    logic [3:0]  wb_sel;
    logic        rf_wen;
    logic        jmp;
    logic [4:0]  wb_addr;
    logic [2:0]  csr;
  } txn_t;

  logic        clk = 1'b0;
  logic        rst, hz;
  logic [31:0] in_pc, in_inst, in_alu, in_rs2, in_imm;
  logic [3:0]  in_mem_wen, in_wb_sel;
  logic        in_rf_wen, in_jmp;
  logic [4:0]  in_wb_addr;
  logic [2:0]  in_csr;
  logic        stall;
  logic [31:0] out_pc, out_inst, out_alu, out_rdata, out_imm;
  logic        out_rf_wen, out_jmp;
  logic [3:0]  out_wb_sel;
  logic [4:0]  out_wb_addr;
  logic [2:0]  out_csr;

  int n_assert = 0;
  int n_fail = 0;
  int stall_cycles = 0;

  memory_stage_if mif();

  memory_stage dut (
    .clk(clk), .rst(rst), .wb_branch_hazard(hz),
    .input_reg_pc(in_pc), .input_inst(in_inst), .input_alu_out(in_alu),
    .input_rs2_data(in_rs2), .input_mem_wen(in_mem_wen), .input_rf_wen(in_rf_wen),
    .input_wb_sel(in_wb_sel), .input_wb_addr(in_wb_addr), .input_csr_cmd(in_csr),
    .input_jmp_flg(in_jmp), .input_imm_i(in_imm),
    .output_stall_flg(stall), .mem(mif),
    .output_reg_pc(out_pc), .output_inst(out_inst), .output_alu_out(out_alu),
    .output_mem_rdata(out_rdata), .output_rf_wen(out_rf_wen), .output_wb_sel(out_wb_sel),
    .output_wb_addr(out_wb_addr), .output_csr_cmd(out_csr), .output_jmp_flg(out_jmp),
    .output_imm_i(out_imm)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input txn_t t);
    in_pc = t.pc; in_inst = t.inst; in_alu = t.alu; in_rs2 = t.rs2; in_imm = t.imm;
    in_mem_wen = t.mem_wen; in_wb_sel = t.wb_sel; in_rf_wen = t.rf_wen;
    in_jmp = t.jmp; in_wb_addr = t.wb_addr; in_csr = t.csr;
  endtask

  function automatic logic is_mem(input txn_t t);
    return (t.mem_wen != 4'd0) || (t.wb_sel >= 4'd1 && t.wb_sel <= 4'd5);
  endfunction

  function automatic logic [3:0] ref_wmask(input txn_t t);
    int lane = int'(t.alu & 32'd3);
    case (t.mem_wen)
      4'd1:    return 4'(1 << lane);
      4'd2:    return (lane >= 2) ? 4'hC : 4'h3;
      4'd3:    return 4'hF;
      default: return 4'h0;
    endcase
  endfunction

  function automatic logic [31:0] ref_wdata(input txn_t t);
    case (t.mem_wen)
      4'd1:    return (t.rs2 & 32'hFF) * 32'h01010101;
      4'd2:    return (t.rs2 & 32'hFFFF) * 32'h00010001;
      default: return t.rs2;
    endcase
  endfunction

  function automatic logic [31:0] ref_load(input txn_t t, input logic [31:0] rd);
    int lane = int'(t.alu & 32'd3);
    logic [31:0] b, h;
    b = (rd >> (8 * lane)) & 32'hFF;
    h = (lane >= 2) ? (rd >> 16) : (rd & 32'hFFFF);
    case (t.wb_sel)
      4'd1:    return (b >= 32'd128) ? b + 32'hFFFFFF00 : b;
      4'd2:    return b;
      4'd3:    return (h >= 32'h8000) ? h + 32'hFFFF0000 : h;
      4'd4:    return h;
      default: return rd;
    endcase
  endfunction

  // op: 0 ADD, 1 SB, 2 SH, 3 SW, 4 LB, 5 LBU, 6 LH, 7 LHU, 8 LW
  function automatic txn_t mk(input int op, input logic [31:0] alu, input logic [31:0] rs2);
    txn_t t;
    t.pc = $urandom; t.inst = $urandom; t.imm = $urandom;
    t.alu = alu; t.rs2 = rs2;
    t.jmp = 1'($urandom); t.wb_addr = 5'($urandom); t.csr = 3'($urandom);
    t.mem_wen = 4'd0; t.wb_sel = 4'd0; t.rf_wen = 1'b0;
    if (op == 0) begin
      t.rf_wen = 1'b1;
      t.wb_sel = ($urandom_range(0, 1) == 0) ? 4'd0 : 4'($urandom_range(6, 15));
    end else if (op <= 3) begin
      t.mem_wen = 4'(op);
    end else begin
      t.wb_sel = 4'(op - 3);
      t.rf_wen = 1'b1;
    end
    return t;
  endfunction

  task automatic check_bubble(input string tag);
    chk({tag, "_pc"}, out_pc, PC_NOP);
    chk({tag, "_inst"}, out_inst, I_NOP);
    chk({tag, "_alu"}, out_alu, 32'hffffffff);
    chk({tag, "_rdata"}, out_rdata, 32'hffffffff);
    chk({tag, "_imm"}, out_imm, 32'hffffffff);
    chk({tag, "_ctl"}, 32'({out_rf_wen, out_wb_sel, out_wb_addr, out_csr, out_jmp}), 32'h0);
  endtask

  task automatic check_wb(input string tag, input txn_t t, input logic [31:0] rd, input logic chk_rd);
    chk({tag, "_pc"}, out_pc, t.pc);
    chk({tag, "_inst"}, out_inst, t.inst);
    chk({tag, "_alu"}, out_alu, t.alu);
    chk({tag, "_imm"}, out_imm, t.imm);
    chk({tag, "_ctl"}, 32'({out_rf_wen, out_wb_sel, out_wb_addr, out_csr, out_jmp}),
        32'({t.rf_wen, t.wb_sel, t.wb_addr, t.csr, t.jmp}));
    if (chk_rd) chk({tag, "_rdata"}, out_rdata, rd);
  endtask

  // Starts at posedge+1 with the DUT idle; returns at posedge+1 after writeback shows the op.
  task automatic run_txn(input txn_t t, input int rdel, input int vdel, input logic [31:0] rd);
    logic st;
    st = (t.mem_wen != 4'd0);
    drive(t);
    #1;
    chk("idle_stall", 32'(stall), 32'd0);
    chk("idle_valid", 32'(mif.mem_cmd_valid), 32'd0);
    tick();
    drive('0);
    if (!is_mem(t)) begin
      check_wb("pass", t, 32'h0, 1'b0);
      return;
    end
    for (int i = 0; i <= rdel; i++) begin
      mif.mem_cmd_ready = (i == rdel);
      #1;
      chk("req_valid", 32'(mif.mem_cmd_valid), 32'd1);
      chk("req_write", 32'(mif.mem_cmd_write), 32'(st));
      chk("req_addr", mif.mem_addr, t.alu & 32'hFFFFFFFC);
      chk("req_wmask", 32'(mif.mem_wmask), 32'(ref_wmask(t)));
      if (st) chk("req_wdata", mif.mem_wdata, ref_wdata(t));
      chk("req_stall", 32'(stall), 32'(!(st && i == rdel)));
      if (stall) stall_cycles++;
      check_bubble("req_out");
      tick();
    end
    mif.mem_cmd_ready = 1'b0;
    if (st) begin
      check_wb("store", t, 32'h0, 1'b0);
      return;
    end
    for (int i = 0; i <= vdel; i++) begin
      mif.mem_rvalid = (i == vdel);
      mif.mem_rdata  = (i == vdel) ? rd : $urandom;
      #1;
      chk("wait_valid", 32'(mif.mem_cmd_valid), 32'd0);
      chk("wait_stall", 32'(stall), 32'(i != vdel));
      if (stall) stall_cycles++;
      tick();
    end
    mif.mem_rvalid = 1'b0;
    check_wb("load", t, ref_load(t, rd), 1'b1);
  endtask

  initial begin
    txn_t t;
    logic [31:0] rd;
    rst = 1'b1; hz = 1'b0;
    mif.mem_cmd_ready = 1'b0; mif.mem_rvalid = 1'b0; mif.mem_rdata = 32'h0;
    drive('0);
    repeat (3) tick();
    chk("rst_stall", 32'(stall), 32'd0);
    chk("rst_valid", 32'(mif.mem_cmd_valid), 32'd0);
    check_bubble("rst_out");
    rst = 1'b0;

    t = mk(0, 32'd5, 32'h0);
    stall_cycles = 0;
    run_txn(t, 0, 0, 32'h0);
    chk("add_alu5", out_alu, 32'd5);
    chk("add_rfwen", 32'(out_rf_wen), 32'd1);
    chk("add_stall_cnt", 32'(stall_cycles), 32'd0);

    t = mk(1, 32'h1002, 32'hAB);
    stall_cycles = 0;
    run_txn(t, 2, 0, 32'h0);
    chk("sb_stall_cnt", 32'(stall_cycles), 32'd2);

    t = mk(4, 32'h2003, 32'h0); run_txn(t, 0, 3, 32'h80112233);
    chk("lb_rdata", out_rdata, 32'hFFFFFF80);
    t = mk(5, 32'h2003, 32'h0); run_txn(t, 0, 3, 32'h80112233);
    chk("lbu_rdata", out_rdata, 32'h00000080);
    t = mk(6, 32'h2002, 32'h0); run_txn(t, 1, 1, 32'h80011234);
    chk("lh_rdata", out_rdata, 32'hFFFF8001);
    t = mk(7, 32'h2002, 32'h0); run_txn(t, 0, 0, 32'h80011234);
    chk("lhu_rdata", out_rdata, 32'h00008001);

    // flush while idle drops the incoming instruction
    drive(mk(0, 32'd9, 32'h0)); hz = 1'b1;
    #1 chk("fidle_valid", 32'(mif.mem_cmd_valid), 32'd0);
    tick(); hz = 1'b0; drive('0);
    check_bubble("fidle_out");

    // flush in REQ: no handshake even with ready high
    drive(mk(3, 32'h3000, 32'h12345678));
    tick(); drive('0); mif.mem_cmd_ready = 1'b1; hz = 1'b1;
    #1 chk("freq_valid", 32'(mif.mem_cmd_valid), 32'd0);
    tick(); hz = 1'b0; mif.mem_cmd_ready = 1'b0;
    check_bubble("freq_out");
    chk("freq_stall", 32'(stall), 32'd0);

    // flush in WAIT_R, data returns two cycles later and is dropped
    drive(mk(8, 32'h4000, 32'h0));
    tick(); drive('0); mif.mem_cmd_ready = 1'b1;
    #1 chk("fw_req_valid", 32'(mif.mem_cmd_valid), 32'd1);
    tick(); mif.mem_cmd_ready = 1'b0; hz = 1'b1;
    #1 chk("fw_stall", 32'(stall), 32'd1);
    tick(); hz = 1'b0; drive(mk(8, 32'h5000, 32'h0));
    #1 chk("drain_valid0", 32'(mif.mem_cmd_valid), 32'd0);
    chk("drain_stall0", 32'(stall), 32'd1);
    check_bubble("drain_out0");
    tick(); mif.mem_rvalid = 1'b1; mif.mem_rdata = 32'hDEADBEEF;
    #1 chk("drain_valid1", 32'(mif.mem_cmd_valid), 32'd0);
    chk("drain_stall1", 32'(stall), 32'd1);
    check_bubble("drain_out1");
    tick(); mif.mem_rvalid = 1'b0; drive('0);
    check_bubble("drain_exit");
    #1 chk("drain_exit_stall", 32'(stall), 32'd0);
    chk("drain_exit_valid", 32'(mif.mem_cmd_valid), 32'd0);
    tick();
    check_wb("post_drain", '0, 32'h0, 1'b0);

    // flush in WAIT_R coinciding with rvalid returns straight to IDLE with a bubble
    drive(mk(8, 32'h6000, 32'h0));
    tick(); drive('0); mif.mem_cmd_ready = 1'b1;
    tick(); mif.mem_cmd_ready = 1'b0; hz = 1'b1; mif.mem_rvalid = 1'b1; mif.mem_rdata = 32'h11111111;
    #1 chk("fwv_stall", 32'(stall), 32'd0);
    tick(); hz = 1'b0; mif.mem_rvalid = 1'b0;
    check_bubble("fwv_out");
    #1 chk("fwv_valid", 32'(mif.mem_cmd_valid), 32'd0);
    tick();

    // reset in REQ with ready high
    drive(mk(3, 32'h7000, 32'hCAFEF00D));
    tick(); drive('0); mif.mem_cmd_ready = 1'b1; rst = 1'b1;
    #1 chk("rreq_valid", 32'(mif.mem_cmd_valid), 32'd0);
    tick(); rst = 1'b0; mif.mem_cmd_ready = 1'b0;
    check_bubble("rreq_out");
    chk("rreq_stall", 32'(stall), 32'd0);
    chk("rreq_valid_after", 32'(mif.mem_cmd_valid), 32'd0);
    mif.mem_rvalid = 1'b1; mif.mem_rdata = 32'h22222222;
    tick(); mif.mem_rvalid = 1'b0;
    chk("stray_stall", 32'(stall), 32'd0);
    chk("stray_valid", 32'(mif.mem_cmd_valid), 32'd0);
    check_wb("stray_pass", '0, 32'h0, 1'b0);

    for (int n = 0; n < 60; n++) begin
      t  = mk($urandom_range(0, 8), $urandom, $urandom);
      rd = $urandom;
      run_txn(t, $urandom_range(0, 3), $urandom_range(0, 3), rd);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
